// File: rtl/keypad_pkg.sv
// ============================================================================
// Module : keypad_pkg
// Brief  : Shared FSM state encoding and width helper for the keypad paint front end.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEB_P = 3'd1,
    PRESS = 3'd2,
    HELD  = 3'd3,
    DEB_R = 3'd4
  } state_t;

  // A candidate is AW+1 bits wide; this value in its top bit means "no key down".
  localparam logic NONE = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scan.sv
// ============================================================================
// Module : keypad_scan
// Brief  : Column rotation, dwell timing, row synchroniser and per-scan key candidate.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_scan
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 50000,
  parameter int AW       = clog2(ROWS * COLS)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COLS-1:0]    col,
  input  logic [ROWS-1:0]    fila,
  output logic [2**AW-1:0]   keys,
  output logic [AW:0]        cand,
  output logic               scan_done
);

  localparam int c_dwell_w = clog2(SCAN_DIV);
  localparam int c_col_w   = clog2(COLS);

  logic [c_dwell_w-1:0] r_dwell;
  logic [c_col_w-1:0]   r_col_idx;
  logic [ROWS-1:0]      r_fila_s1, r_fila_s2;
  logic [2**AW-1:0]     r_mask, r_keys, w_mask;
  logic [AW:0]          r_cand, w_low;
  logic                 r_scan_done;
  logic                 w_last_dwell, w_last_col;

  assign col          = ~(COLS'(1) << r_col_idx);
  assign w_last_dwell = (r_dwell == c_dwell_w'(SCAN_DIV - 1));
  assign w_last_col   = (r_col_idx == c_col_w'(COLS - 1));

  // Refresh the bits of the column currently driven low; other columns keep last sample.
  always_comb begin
    w_mask = r_mask;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (c == int'(r_col_idx)) w_mask[r*COLS+c] = ~r_fila_s2[r];
      end
    end
  end

  always_comb begin
    w_low = '1;
    for (int i = ROWS * COLS - 1; i >= 0; i--) begin
      if (w_mask[i]) w_low = (AW+1)'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwell     <= '0;
      r_col_idx   <= '0;
      r_fila_s1   <= '1;
      r_fila_s2   <= '1;
      r_mask      <= '0;
      r_keys      <= '0;
      r_cand      <= '1;
      r_scan_done <= 1'b0;
    end else begin
      r_fila_s1   <= fila;
      r_fila_s2   <= r_fila_s1;
      r_scan_done <= 1'b0;
      if (w_last_dwell) begin
        r_dwell <= '0;
        r_mask  <= w_mask;
        if (w_last_col) begin
          r_col_idx   <= '0;
          r_keys      <= w_mask;
          r_cand      <= w_low;
          r_scan_done <= 1'b1;
        end else begin
          r_col_idx <= r_col_idx + c_col_w'(1);
        end
      end else begin
        r_dwell <= r_dwell + c_dwell_w'(1);
      end
    end
  end

  assign keys      = r_keys;
  assign cand      = r_cand;
  assign scan_done = r_scan_done;

endmodule

`default_nettype wire

// File: rtl/keypad_paint_ctrl.sv
// ============================================================================
// Module : keypad_paint_ctrl
// Brief  : Debounced matrix keypad to colour-bank writer; optional tone when
//          KEYPAD_TONE_EN is defined (otherwise tone_out is tied low).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_paint_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int COLOR_W   = 3,
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_N     = 3,
  parameter int TONE_BASE = 25000,
  parameter int TONE_STEP = 1000
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic [COLS-1:0]                 col,
  input  logic [ROWS-1:0]                 fila,
  output logic [clog2(ROWS*COLS)-1:0]     key_code,
  output logic                            key_held,
  output logic                            wr_en,
  output logic [clog2(ROWS*COLS)-1:0]     wr_addr,
  output logic [COLOR_W-1:0]              wr_data,
  output logic                            tone_out
);

  localparam int c_aw = clog2(ROWS * COLS);
  localparam int c_nk = 2 ** c_aw;
  localparam int c_dw = clog2(DEB_N + 1);

  logic [c_nk-1:0]    w_keys;
  logic [c_aw:0]      w_cand;
  logic               w_scan_done;

  state_t             r_state, w_next;
  logic [c_dw-1:0]    r_deb, w_deb_next, w_deb_inc;
  logic [c_aw-1:0]    r_key, w_key_next, r_key_code;
  logic               r_key_held, r_wr_en;
  logic [COLOR_W-1:0] r_wr_data, w_colour_new;
  logic [COLOR_W-1:0] r_colour [c_nk];

  keypad_scan #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV),
    .AW       (c_aw)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .fila      (fila),
    .keys      (w_keys),
    .cand      (w_cand),
    .scan_done (w_scan_done)
  );

  assign w_deb_inc    = r_deb + c_dw'(1);
  assign w_colour_new = r_colour[r_key] + COLOR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Press debounce follows the lowest-index candidate; release debounce follows the held key itself.
  always_comb begin
    w_next     = r_state;
    w_deb_next = r_deb;
    w_key_next = r_key;
    case (r_state)
      IDLE: begin
        if (w_scan_done && (w_cand[c_aw] != NONE)) begin
          w_key_next = w_cand[c_aw-1:0];
          w_deb_next = c_dw'(1);
          w_next     = (DEB_N == 1) ? PRESS : DEB_P;
        end
      end
      DEB_P: begin
        if (w_scan_done) begin
          if (w_cand == {1'b0, r_key}) begin
            w_deb_next = w_deb_inc;
            if (w_deb_inc == c_dw'(DEB_N)) w_next = PRESS;
          end else begin
            w_next = IDLE;
          end
        end
      end
      PRESS: w_next = HELD;
      HELD: begin
        if (w_scan_done && !w_keys[r_key]) begin
          w_deb_next = c_dw'(1);
          w_next     = (DEB_N == 1) ? IDLE : DEB_R;
        end
      end
      DEB_R: begin
        if (w_scan_done) begin
          if (!w_keys[r_key]) begin
            w_deb_next = w_deb_inc;
            if (w_deb_inc == c_dw'(DEB_N)) w_next = IDLE;
          end else begin
            w_next = HELD;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb      <= '0;
      r_key      <= '0;
      r_key_code <= '0;
      r_key_held <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      for (int i = 0; i < c_nk; i++) r_colour[i] <= '0;
    end else begin
      r_deb      <= w_deb_next;
      r_key      <= w_key_next;
      r_key_held <= (w_next == HELD) || (w_next == DEB_R);
      r_wr_en    <= (r_state == PRESS);
      if (r_state == PRESS) begin
        r_colour[r_key] <= w_colour_new;
        r_wr_data       <= w_colour_new;
        r_key_code      <= r_key;
      end
    end
  end

  assign key_code = r_key_code;
  assign wr_addr  = r_key_code;
  assign key_held = r_key_held;
  assign wr_en    = r_wr_en;
  assign wr_data  = r_wr_data;

`ifdef KEYPAD_TONE_EN
  localparam int c_tw = clog2(((TONE_BASE > TONE_STEP) ? TONE_BASE : TONE_STEP) + 1);

  int              w_hp;
  logic [c_tw-1:0] w_half, r_tone_cnt;
  logic            r_tone;

  always_comb begin
    w_hp = TONE_BASE - int'(r_key_code) * TONE_STEP;
    if (w_hp < TONE_STEP) w_hp = TONE_STEP;
    w_half = c_tw'(w_hp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tone_cnt <= '0;
      r_tone     <= 1'b0;
    end else if (!r_key_held) begin
      r_tone_cnt <= '0;
      r_tone     <= 1'b0;
    end else if (r_tone_cnt == w_half - c_tw'(1)) begin
      r_tone_cnt <= '0;
      r_tone     <= ~r_tone;
    end else begin
      r_tone_cnt <= r_tone_cnt + c_tw'(1);
    end
  end

  assign tone_out = r_tone;
`else
  logic w_unused_tone;
  assign w_unused_tone = ^{TONE_BASE, TONE_STEP};
  assign tone_out      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_keypad_paint_ctrl.sv
// ============================================================================
// Module : tb_keypad_paint_ctrl
// Brief  : Directed self-checking bench with a behavioural 4x4 keypad matrix.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_keypad_paint_ctrl;

  localparam int SCAN = 32;  // SCAN_DIV 8 x 4 columns

  logic       clk, rst;
  logic [3:0] col, fila;
  logic [3:0] key_code, wr_addr;
  logic       key_held, wr_en, tone_out;
  logic [2:0] wr_data;

  logic [15:0] pressed;
  int          n_checks, n_fail, wr_cnt, cyc;
  logic [3:0]  last_addr;
  logic [2:0]  last_data;

  keypad_paint_ctrl #(
    .ROWS(4), .COLS(4), .COLOR_W(3), .SCAN_DIV(8), .DEB_N(3),
    .TONE_BASE(20), .TONE_STEP(4)
  ) dut (
    .clk(clk), .rst(rst), .col(col), .fila(fila), .key_code(key_code),
    .key_held(key_held), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .tone_out(tone_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    fila = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && pressed[r*4+c]) fila[r] = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= wr_addr;
      last_data <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_wr(input string tag, input int start_cnt);
    int n;
    n = 0;
    while (wr_cnt == start_cnt && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({tag, "_wr_seen"}, (wr_cnt != start_cnt), 1);
  endtask

  task automatic wait_release(input string tag);
    int n;
    n = 0;
    while (key_held && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_released"}, key_held, 0);
  endtask

  task automatic press_cycle(input int key, input int exp_data, input string tag);
    int c0;
    c0 = wr_cnt;
    pressed[key] = 1'b1;
    wait_wr(tag, c0);
    check({tag, "_addr"}, last_addr, key);
    check({tag, "_data"}, last_data, exp_data);
    check({tag, "_held"}, key_held, 1);
    repeat (4 * SCAN) @(negedge clk);
    check({tag, "_no_repeat"}, wr_cnt, c0 + 1);
    pressed[key] = 1'b0;
    wait_release(tag);
  endtask

  task automatic wait_tone_rise(output int t);
    int n;
    n = 0;
    while (tone_out && n < 200) begin @(negedge clk); n++; end
    while (!tone_out && n < 200) begin @(negedge clk); n++; end
    t = cyc;
  endtask

  initial begin
    int c0, t1, t2, hi;
    n_checks = 0; n_fail = 0; wr_cnt = 0; cyc = 0;
    pressed = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col", col, 4'b1110);
    check("rst_held", key_held, 0);
    check("rst_code", key_code, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_tone", tone_out, 0);
    rst = 1'b0;

    // single press then wrap of the per-cell colour
    for (int k = 1; k <= 8; k++) press_cycle(5, k % 8, $sformatf("k5_p%0d", k));
    check("k5_total_writes", wr_cnt, 8);

    // bounce: key 2 visible for at most two scans
    c0 = wr_cnt;
    pressed[2] = 1'b1;
    repeat (60) @(negedge clk);
    pressed[2] = 1'b0;
    repeat (6 * SCAN) @(negedge clk);
    check("bounce_no_wr", wr_cnt, c0);
    check("bounce_held", key_held, 0);
    press_cycle(2, 1, "k2_after_bounce");

    // two keys: lowest index wins, other accepted after release
    c0 = wr_cnt;
    pressed[3] = 1'b1;
    pressed[9] = 1'b1;
    wait_wr("dual", c0);
    check("dual_addr", last_addr, 3);
    check("dual_data", last_data, 1);
    repeat (2 * SCAN) @(negedge clk);
    check("dual_single_wr", wr_cnt, c0 + 1);
    pressed[3] = 1'b0;
    wait_release("dual_rel3");
    wait_wr("k9", c0 + 1);
    check("k9_addr", last_addr, 9);
    check("k9_data", last_data, 1);
    check("k9_code", key_code, 9);
    check("k9_held", key_held, 1);

    // asynchronous reset while key 9 held and scan away from column 0
    for (int n = 0; n < 40 && col == 4'b1110; n++) @(negedge clk);
    check("pre_rst_col_moved", (col != 4'b1110), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_col", col, 4'b1110);
    check("arst_held", key_held, 0);
    check("arst_code", key_code, 0);
    check("arst_wr_addr", wr_addr, 0);
    check("arst_wr_data", wr_data, 0);
    check("arst_wr_en", wr_en, 0);
    check("arst_tone", tone_out, 0);
    pressed = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    press_cycle(3, 1, "k3_after_rst");

    // tone on key 0
    c0 = wr_cnt;
    pressed[0] = 1'b1;
    wait_wr("k0", c0);
    check("k0_addr", last_addr, 0);
    check("k0_data", last_data, 1);
`ifdef KEYPAD_TONE_EN
    wait_tone_rise(t1);
    wait_tone_rise(t2);
    check("tone_period", t2 - t1, 40);
`else
    hi = 0;
    repeat (200) begin
      @(negedge clk);
      if (tone_out) hi++;
    end
    check("tone_disabled", hi, 0);
`endif
    pressed[0] = 1'b0;
    wait_release("k0");
    @(negedge clk);
    check("tone_after_release", tone_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
